// File: rtl/uart_rx_ser.sv
// UART receiver: 2-flop line synchroniser, mid-bit sampling FSM, stop-bit check,
// and a one-entry holding register with valid/ready handshake.
module uart_rx_ser #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_rx_s;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_byte;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;

  logic w_cnt_clr;
  logic w_cnt_run;
  logic w_bit_clr;
  logic w_shift_en;
  logic w_load;
  logic w_ferr;
  logic w_ovr;
  logic w_consume;

  assign w_consume = r_valid & rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_data;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_run   = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    w_ovr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        w_cnt_run = 1'b1;
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr = 1'b1;
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_bit_clr   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_cnt_run = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == IDX_LAST) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_cnt_run = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
            // A byte being consumed on this same edge frees the slot for the new one.
            if (!r_valid || w_consume) begin
              w_load = 1'b1;
            end else begin
              w_ovr = 1'b1;
            end
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_run) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + BW'(1);
      end
      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_ovr;
      if (w_load) begin
        r_byte  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_byte   = r_byte;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ser.sv
// Bench for uart_rx_ser: directed scenarios plus random frames, checked by a
// transaction-level model feeding expected-byte and expected-flag queues.
module tb_uart_rx_ser;

  localparam int N  = 16;
  localparam int D  = 8;
  localparam int H  = N / 2;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_data;
  logic [D-1:0] rx_byte;
  logic         rx_valid;
  logic         rx_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [D-1:0] exp_bytes[$];
  int           exp_evt[$];
  bit           m_full     = 1'b0;
  bit           auto_ready = 1'b0;

  uart_rx_ser #(.CLKS_PER_BIT(N), .DATA_BITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Frame-level model: decides what the receiver must report for a frame.
  function automatic void expect_frame(input logic [D-1:0] d, input bit stop_ok, input bit consumed);
    if (!stop_ok) begin
      exp_evt.push_back(EV_FERR);
    end else if (m_full && !consumed && !auto_ready) begin
      exp_evt.push_back(EV_OVR);
    end else begin
      exp_bytes.push_back(d);
      m_full = !auto_ready;
    end
  endfunction

  task automatic sync_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_data = v;
    repeat (N) @(negedge clk);
  endtask

  task automatic send_frame(input logic [D-1:0] d, input logic stop);
    logic [D-1:0] sh;
    sh = d;
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < D; i++) begin
      drive_bit(sh[0]);
      sh = sh >> 1;
    end
    drive_bit(stop);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    rx_ready = 1'b1;
    m_full   = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    check("ready_clears_valid", 32'(rx_valid), 32'd0);
  endtask

  // Monitor: compares loads and flag pulses against the model queues.
  initial begin
    logic         prev_valid;
    logic         prev_ready;
    logic [D-1:0] cur_exp;
    int           ev;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    cur_exp    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        continue;
      end
      if (rx_valid && (!prev_valid || prev_ready)) begin
        if (exp_bytes.size() == 0) begin
          fail_unexp("unexpected_byte", 32'(rx_byte));
        end else begin
          cur_exp = exp_bytes.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(cur_exp));
        end
      end
      if (prev_valid && !prev_ready) begin
        check("valid_held", 32'(rx_valid), 32'd1);
        check("byte_held", 32'(rx_byte), 32'(cur_exp));
      end
      if (frame_err) begin
        ev = (exp_evt.size() != 0) ? exp_evt.pop_front() : 0;
        check("frame_err_event", 32'(ev), 32'(EV_FERR));
      end
      if (overrun) begin
        ev = (exp_evt.size() != 0) ? exp_evt.pop_front() : 0;
        check("overrun_event", 32'(ev), 32'(EV_OVR));
      end
      if (frame_err && overrun) begin
        fail_unexp("ferr_and_overrun_together", 32'd1);
      end
      prev_valid = rx_valid;
      prev_ready = rx_ready;
    end
  end

  initial begin
    int           nbusy;
    int           wait_cycles;
    logic [D-1:0] d;
    logic [D-1:0] f0;
    bit           ok;

    rst      = 1'b1;
    rx_data  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_byte", 32'(rx_byte), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with latency check
    sync_clk();
    expect_frame(8'hA5, 1'b1, 1'b0);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        check("a5_valid_before_T0_153", 32'(rx_valid), 32'd0);
        @(posedge clk);
        #1;
        check("a5_valid_at_T0_153", 32'(rx_valid), 32'd1);
        check("a5_byte_at_T0_153", 32'(rx_byte), 32'hA5);
      end
    join
    repeat (5) @(negedge clk);
    pulse_ready();

    // Glitch: 3-cycle low pulse
    repeat (4) @(negedge clk);
    sync_clk();
    nbusy = 0;
    fork
      begin
        @(negedge clk);
        rx_data = 1'b0;
        repeat (3) @(negedge clk);
        rx_data = 1'b1;
      end
      begin
        repeat (24) begin
          @(posedge clk);
          #1;
          if (busy) nbusy++;
        end
      end
    join
    check("glitch_busy_cycles", 32'(nbusy), 32'(H));
    check("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Frame error and break
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (40 * N) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    check("break_no_valid", 32'(rx_valid), 32'd0);
    rx_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("break_busy_until_high", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("break_idle_after_high", 32'(busy), 32'd0);
    expect_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    pulse_ready();

    // Overrun: two frames with consumer stalled
    expect_frame(8'h11, 1'b1, 1'b0);
    expect_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check("overrun_keeps_old", 32'(rx_byte), 32'h11);
    pulse_ready();

    // Consume exactly on the stop-sample edge
    expect_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    sync_clk();
    expect_frame(8'h66, 1'b1, 1'b1);
    fork
      send_frame(8'h66, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        check("col_valid_stays", 32'(rx_valid), 32'd1);
        check("col_new_byte", 32'(rx_byte), 32'h66);
      end
    join
    repeat (3) @(negedge clk);
    pulse_ready();

    // Reset during data bit 4 of 0xF0
    f0 = 8'hF0;
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(f0[i]);
    rx_data = f0[4];
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rx_byte", 32'(rx_byte), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rx_data = 1'b1;
    m_full  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Continuous consumer from here on
    auto_ready = 1'b1;
    rx_ready   = 1'b1;
    expect_frame(8'h0F, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);

    // Random frames, gaps and occasional bad stop bits
    for (int k = 0; k < 24; k++) begin
      d  = D'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      expect_frame(d, ok, 1'b0);
      send_frame(d, ok);
      if (!ok) begin
        repeat ($urandom_range(0, 3) * N) @(negedge clk);
        rx_data = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end

    wait_cycles = 0;
    while ((exp_bytes.size() != 0 || exp_evt.size() != 0) && wait_cycles < 2000) begin
      @(negedge clk);
      wait_cycles++;
    end
    repeat (4) @(negedge clk);
    check("bytes_outstanding", 32'(exp_bytes.size()), 32'd0);
    check("events_outstanding", 32'(exp_evt.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ser.md
# uart_rx_ser

Serial-to-parallel UART receiver for the slave end of the single-wire UART link, where one `data` line is driven by the transmitter and sampled here. It synchronises the line, detects start bits, samples each bit at mid-bit using a fixed clocks-per-bit divider and checks the stop bit. Received bytes go into a one-entry holding register with a valid/ready handshake toward the LTPI/SMBus-relay logic that consumes them.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per UART bit; even, minimum 4.
- `DATA_BITS`, 8: data bits per frame; range 5..8; LSB first; no parity.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx_data`  in  1  serial line from the UART link; idle high; asynchronous to `clk`.
- `rx_byte`  out  DATA_BITS  received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts `rx_byte` on a cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser.** Two-flop synchroniser on `rx_data`, producing `rx_s`. Both flops reset to 1. All logic below uses `rx_s` only.
- **Counters.** `cnt` has width clog2(CLKS_PER_BIT). `bit_idx` has width clog2(DATA_BITS+1).
- **IDLE**
  - If `rx_s == 0`: go to START, `cnt <= 0`.
- **START**
  - `cnt` increments each cycle.
  - At `cnt == CLKS_PER_BIT/2-1`, sample `rx_s`:
    - 0: go to DATA with `cnt <= 0`, `bit_idx <= 0`.
    - 1: false start (glitch); go to IDLE with no output activity.
- **DATA**
  - At `cnt == CLKS_PER_BIT-1`, sample `rx_s`, shift it into the MSB of the shift register (right shift, so the result is LSB first), `cnt <= 0`, `bit_idx++`.
  - After sample number DATA_BITS, go to STOP.
- **STOP**
  - At `cnt == CLKS_PER_BIT-1`, sample `rx_s`:
    - 1 and the holding register is free, or being consumed this same cycle (`rx_valid && rx_ready`): load `rx_byte`, `rx_valid <= 1`, go to IDLE.
    - 1 and the holding register is full and not consumed this cycle: pulse `overrun`, discard the new byte, keep the old byte, go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rx_s == 1`, then go to IDLE. This prevents a break condition from being re-detected as start bits.
- **Handshake.** `rx_valid` clears on an edge where `rx_valid && rx_ready`, unless a new byte loads on that same edge, in which case it stays 1 with the new data. `rx_ready` is ignored while `rx_valid` is 0.
- **Reset.** Reset at any time, including mid-frame, returns to IDLE and discards any partial frame.
  - Outputs in reset: `rx_byte = 0`, `rx_valid = 0`, `frame_err = 0`, `overrun = 0`, `busy = 0`.
  - Shift register, `cnt` and `bit_idx` reset to 0.

## Timing
- Synchroniser latency: 2 clk cycles from `rx_data` to `rx_s`.
- Let T0 be the edge where IDLE sees `rx_s == 0`. With N = CLKS_PER_BIT and H = N/2:
  - Start bit is sampled at T0+H.
  - Data bit i (0-based) is sampled at T0+H+(i+1)·N.
  - Stop bit is sampled at T0+H+(DATA_BITS+1)·N.
- `rx_valid`, `frame_err` and `overrun` become visible in the cycle after the stop-sample edge. For N=16, D=8 that is T0+153.
- Receiver is back in IDLE one cycle after the stop sample. A start bit immediately following the stop bit (half-bit stop margin) is accepted.
- `frame_err` and `overrun` are registered one-cycle pulses and are never asserted together.
- No combinational path from `rx_ready` to any output.

## Test plan
- **Single byte.** Send 0xA5 (N=16, D=8), `rx_ready = 0`. Expect `rx_valid = 1` with `rx_byte = 0xA5` at T0+153, held until `rx_ready` is pulsed, then `rx_valid = 0` on the next cycle.
- **Glitch.** Drive a 3-cycle low pulse on an idle line. Expect `busy` high for exactly H cycles, then IDLE, with no `rx_valid`, `frame_err` or `overrun`.
- **Frame error.** Send 0x3C with the stop bit low and hold the line low for 40 more bit times. Expect one `frame_err` pulse, `rx_valid` stays 0, and `busy` stays high until the line returns high. A following 0x81 frame is received correctly.
- **Overrun.** Send 0x11 then 0x22 back-to-back with `rx_ready = 0`. Expect `rx_byte = 0x11` retained, one `overrun` pulse at the end of the second frame, and `rx_valid` continuously 1.
- **Consume on load.** Send 0x55, 0x66. Assert `rx_ready` exactly on the stop-sample edge of 0x66. Expect no `overrun`, `rx_byte` changes 0x55→0x66, and `rx_valid` stays 1.
- **Reset mid-frame.** Assert `rst` during data bit 4 of 0xF0. Expect all outputs 0 immediately. After release, 0x0F is received correctly with no spurious flags.
